// File: rtl/dc_sweep_sequencer.sv
// dc_sweep_sequencer
//   Two-axis DC sweep sequencer for a three-terminal device. Vgs is the outer loop and
//   Vds is the inner loop. After every bias change it waits settle_cycles+1 cycles, requests
//   one drain-current conversion, and streams (vgs_idx, vds_idx, Id) over a valid/ready port.
//
// Ports
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   start                one-cycle pulse, honoured only in IDLE
//   vgs_*/vds_*          start code, unsigned step and point count per axis (sampled in LOAD)
//   settle_cycles        wait cycles after each bias update (sampled in LOAD)
//   dac_vgs/dac_vds      bias DAC codes; dac_load strobes for one cycle when either changes
//   adc_req/adc_ack      conversion handshake; adc_data is valid together with adc_ack
//   res_*                result stream (valid/ready), raster order
//   busy/done            busy outside IDLE; done pulses at completion or abort
//
// Optional feature, enabled by defining SWEEP_COMPLIANCE_EN:
//   compliance_limit (in) and compliance_hit (out, sticky, cleared in LOAD). A result with
//   |Id| > compliance_limit is still delivered, then the sweep aborts with dac_vds=0 and
//   dac_vgs=vgs_start.
module dc_sweep_sequencer #(
  parameter int unsigned CODE_W   = 12,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned SETTLE_W = 16,
  parameter int unsigned DATA_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CODE_W-1:0]   vgs_start,
  input  logic [CODE_W-1:0]   vgs_step,
  input  logic [CNT_W-1:0]    vgs_count,
  input  logic [CODE_W-1:0]   vds_start,
  input  logic [CODE_W-1:0]   vds_step,
  input  logic [CNT_W-1:0]    vds_count,
  input  logic [SETTLE_W-1:0] settle_cycles,
  output logic [CODE_W-1:0]   dac_vgs,
  output logic [CODE_W-1:0]   dac_vds,
  output logic                dac_load,
  output logic                adc_req,
  input  logic                adc_ack,
  input  logic [DATA_W-1:0]   adc_data,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [CNT_W-1:0]    res_vgs_idx,
  output logic [CNT_W-1:0]    res_vds_idx,
  output logic [DATA_W-1:0]   res_id,
`ifdef SWEEP_COMPLIANCE_EN
  input  logic [DATA_W-1:0]   compliance_limit,
  output logic                compliance_hit,
`endif
  output logic                busy,
  output logic                done
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLoad    = 3'd1;
  localparam logic [2:0] StSettle  = 3'd2;
  localparam logic [2:0] StMeasure = 3'd3;
  localparam logic [2:0] StOutput  = 3'd4;
  localparam logic [2:0] StAdvance = 3'd5;

  localparam logic [CNT_W-1:0]    CntOne    = CNT_W'(1);
  localparam logic [SETTLE_W-1:0] SettleOne = SETTLE_W'(1);

  // Saturating unsigned add: the carry out of the CODE_W-bit sum clamps to full scale.
  function automatic logic [CODE_W-1:0] sat_add(input logic [CODE_W-1:0] a,
                                                input logic [CODE_W-1:0] b);
    logic [CODE_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CODE_W] ? {CODE_W{1'b1}} : sum[CODE_W-1:0];
  endfunction

  logic [2:0]          state_q, state_d;
  logic [CODE_W-1:0]   vgs_step_q, vgs_step_d;
  logic [CNT_W-1:0]    vgs_count_q, vgs_count_d;
  logic [CODE_W-1:0]   vds_start_q, vds_start_d;
  logic [CODE_W-1:0]   vds_step_q, vds_step_d;
  logic [CNT_W-1:0]    vds_count_q, vds_count_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [CNT_W-1:0]    vgs_idx_q, vgs_idx_d;
  logic [CNT_W-1:0]    vds_idx_q, vds_idx_d;
  logic [CODE_W-1:0]   dac_vgs_q, dac_vgs_d;
  logic [CODE_W-1:0]   dac_vds_q, dac_vds_d;
  logic                dac_load_q, dac_load_d;
  logic                adc_req_q, adc_req_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_id_q, res_id_d;
  logic                done_q, done_d;
  logic                abort;

`ifdef SWEEP_COMPLIANCE_EN
  logic [CODE_W-1:0]   vgs_start_q, vgs_start_d;
  logic [DATA_W-1:0]   limit_q, limit_d;
  logic                hit_q, hit_d;
  logic [DATA_W:0]     id_mag;

  // One extra bit so the most negative code maps to 2^(DATA_W-1) instead of wrapping.
  always_comb begin
    id_mag = {res_id_q[DATA_W-1], res_id_q};
    if (res_id_q[DATA_W-1]) begin
      id_mag = ~id_mag + {{DATA_W{1'b0}}, 1'b1};
    end
  end

  assign abort = (id_mag > {1'b0, limit_q});
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    vgs_step_d   = vgs_step_q;
    vgs_count_d  = vgs_count_q;
    vds_start_d  = vds_start_q;
    vds_step_d   = vds_step_q;
    vds_count_d  = vds_count_q;
    settle_d     = settle_q;
    settle_cnt_d = settle_cnt_q;
    vgs_idx_d    = vgs_idx_q;
    vds_idx_d    = vds_idx_q;
    dac_vgs_d    = dac_vgs_q;
    dac_vds_d    = dac_vds_q;
    dac_load_d   = 1'b0;
    adc_req_d    = adc_req_q;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    done_d       = 1'b0;
`ifdef SWEEP_COMPLIANCE_EN
    vgs_start_d  = vgs_start_q;
    limit_d      = limit_q;
    hit_d        = hit_q;
`endif

    case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end

      StLoad: begin
        vgs_step_d  = vgs_step;
        vgs_count_d = vgs_count;
        vds_start_d = vds_start;
        vds_step_d  = vds_step;
        vds_count_d = vds_count;
        settle_d    = settle_cycles;
`ifdef SWEEP_COMPLIANCE_EN
        vgs_start_d = vgs_start;
        limit_d     = compliance_limit;
        hit_d       = 1'b0;
`endif
        if (vgs_count == '0 || vds_count == '0) begin
          // Empty sweep: report completion without touching the bias.
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          dac_vgs_d    = vgs_start;
          dac_vds_d    = vds_start;
          vgs_idx_d    = '0;
          vds_idx_d    = '0;
          dac_load_d   = 1'b1;
          settle_cnt_d = settle_cycles;
          state_d      = StSettle;
        end
      end

      StSettle: begin
        if (settle_cnt_q == '0) begin
          adc_req_d = 1'b1;
          state_d   = StMeasure;
        end else begin
          settle_cnt_d = settle_cnt_q - SettleOne;
        end
      end

      StMeasure: begin
        if (adc_ack) begin
          res_id_d    = adc_data;
          adc_req_d   = 1'b0;
          res_valid_d = 1'b1;
          state_d     = StOutput;
        end
      end

      StOutput: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StAdvance;
        end
      end

      StAdvance: begin
        if (abort) begin
          dac_vds_d  = '0;
`ifdef SWEEP_COMPLIANCE_EN
          dac_vgs_d  = vgs_start_q;
          hit_d      = 1'b1;
`endif
          dac_load_d = 1'b1;
          done_d     = 1'b1;
          state_d    = StIdle;
        end else if (vds_idx_q != vds_count_q - CntOne) begin
          vds_idx_d    = vds_idx_q + CntOne;
          dac_vds_d    = sat_add(dac_vds_q, vds_step_q);
          dac_load_d   = 1'b1;
          settle_cnt_d = settle_q;
          state_d      = StSettle;
        end else if (vgs_idx_q != vgs_count_q - CntOne) begin
          vds_idx_d    = '0;
          dac_vds_d    = vds_start_q;
          vgs_idx_d    = vgs_idx_q + CntOne;
          dac_vgs_d    = sat_add(dac_vgs_q, vgs_step_q);
          dac_load_d   = 1'b1;
          settle_cnt_d = settle_q;
          state_d      = StSettle;
        end else begin
          // Final point: DAC codes are left at the last bias on purpose.
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      vgs_step_q   <= '0;
      vgs_count_q  <= '0;
      vds_start_q  <= '0;
      vds_step_q   <= '0;
      vds_count_q  <= '0;
      settle_q     <= '0;
      settle_cnt_q <= '0;
      vgs_idx_q    <= '0;
      vds_idx_q    <= '0;
      dac_vgs_q    <= '0;
      dac_vds_q    <= '0;
      dac_load_q   <= 1'b0;
      adc_req_q    <= 1'b0;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      done_q       <= 1'b0;
`ifdef SWEEP_COMPLIANCE_EN
      vgs_start_q  <= '0;
      limit_q      <= '0;
      hit_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      vgs_step_q   <= vgs_step_d;
      vgs_count_q  <= vgs_count_d;
      vds_start_q  <= vds_start_d;
      vds_step_q   <= vds_step_d;
      vds_count_q  <= vds_count_d;
      settle_q     <= settle_d;
      settle_cnt_q <= settle_cnt_d;
      vgs_idx_q    <= vgs_idx_d;
      vds_idx_q    <= vds_idx_d;
      dac_vgs_q    <= dac_vgs_d;
      dac_vds_q    <= dac_vds_d;
      dac_load_q   <= dac_load_d;
      adc_req_q    <= adc_req_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      done_q       <= done_d;
`ifdef SWEEP_COMPLIANCE_EN
      vgs_start_q  <= vgs_start_d;
      limit_q      <= limit_d;
      hit_q        <= hit_d;
`endif
    end
  end

  assign dac_vgs     = dac_vgs_q;
  assign dac_vds     = dac_vds_q;
  assign dac_load    = dac_load_q;
  assign adc_req     = adc_req_q;
  assign res_valid   = res_valid_q;
  assign res_vgs_idx = vgs_idx_q;
  assign res_vds_idx = vds_idx_q;
  assign res_id      = res_id_q;
  assign busy        = (state_q != StIdle);
  assign done        = done_q;
`ifdef SWEEP_COMPLIANCE_EN
  assign compliance_hit = hit_q;
`endif

endmodule
